test: RTL and testbench
=======================

TEST -- requirements
Module: test

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, packet width in bits (min 9); DEPTH, default 8, per-device input FIFO entries (power of 2, >=2); DEVICES, default 4, attached devices (2..16).
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  DEVICES  per-device write strobe.
- d_in  in  DEVICES*WIDTH  per-device packet; slice i = [i*WIDTH +: WIDTH].
- full  out  DEVICES  per-device FIFO full flag.
- d_out  out  DEVICES*WIDTH  per-device delivered packet.
- d_out_vld  out  DEVICES  per-device delivery strobe, one cycle per packet.
REQ-003 Packet format SHALL be: [WIDTH-1:WIDTH-8] destination ID; [WIDTH-9:0] payload. ID 8'hFF = broadcast.

Function
REQ-004 Each device SHALL own one FIFO, DEPTH entries, first-in-first-out order.
REQ-005 push[i]=1 with full[i]=0 SHALL write d_in slice i at that rising edge.
REQ-006 push[i]=1 with full[i]=1 SHALL be ignored; FIFO contents and count unchanged.
REQ-007 full[i] SHALL be registered and equal (count[i]==DEPTH).
REQ-008 A round-robin arbiter SHALL grant at most one non-empty FIFO per cycle and pop its head word in that cycle.
REQ-009 Arbitration search SHALL start at (last granted index + 1) mod DEVICES; after reset it starts at index 0.
REQ-010 A word pushed at edge t SHALL be eligible for grant in the cycle after t; if granted there, d_out/d_out_vld SHALL assert after the next edge (push-to-delivery latency 2 cycles when idle).
REQ-011 Granted word with destination d < DEVICES SHALL appear on d_out slice d with d_out_vld[d]=1 for exactly one cycle; all other vld bits 0.
REQ-012 Destination d == source index SHALL be delivered to the source (loopback allowed).
REQ-013 Broadcast (8'hFF) SHALL be delivered simultaneously to every device except the source, identical word on each slice.
REQ-014 Destination d >= DEVICES and != 8'hFF SHALL be dropped: popped, no vld asserted.
REQ-015 Push and pop of the same FIFO in one cycle SHALL both occur when not full; count unchanged.
REQ-016 d_out slices SHALL hold their last value when vld is 0.
REQ-017 Pointer and count wrap-around SHALL be modulo DEPTH without loss or duplication.

Reset
REQ-018 rst_n=0 SHALL immediately clear all FIFO counts and pointers, full=0, d_out=0, d_out_vld=0, arbiter pointer to start at 0.
REQ-019 Reset mid-operation SHALL discard all queued and in-flight packets; no vld asserts for them after release.
REQ-020 Pushes while rst_n=0 SHALL be ignored.

Configuration
REQ-021 With macro TEST_DROP_CNT_EN defined, the module SHALL add output drop_cnt (16 bits), counting REQ-006 rejected pushes plus REQ-014 dropped packets, saturating at 16'hFFFF, reset to 0; both events in one cycle add their total.
REQ-022 Without TEST_DROP_CNT_EN, drop_cnt and its logic SHALL not exist; all other behaviour is identical.

Verification (WIDTH=16, DEPTH=8, DEVICES=4)
REQ-023 Single unicast: device 0 pushes 16'h02A5 once -> 2 cycles later d_out slice 2 = 16'h02A5, d_out_vld = 4'b0100 for one cycle.
REQ-024 Broadcast: device 1 pushes 16'hFF3C -> d_out_vld = 4'b1101, slices 0, 2, 3 = 16'hFF3C.
REQ-025 Full: device 3 pushes 9 words in consecutive cycles with arbiter starved by reset-held pattern -> full[3]=1 after 8th accepted; 9th ignored; exactly 8 deliveries in order.
REQ-026 Fairness: all 4 devices push one word to device 0 in the same cycle -> deliveries on slice 0 over 4 consecutive cycles in source order 0,1,2,3.
REQ-027 Drop and reset: push 16'h0711 (dest 7) -> no vld; with TEST_DROP_CNT_EN, drop_cnt=1. Then queue 3 words, assert rst_n=0 -> full=0, no vld after release, drop_cnt=0.

Source files
------------

// File: rtl/test.sv
// test -- multi-device packet switch with per-device input FIFOs.
//
// Every attached device owns a DEPTH-entry FIFO. A round-robin arbiter pops
// at most one FIFO head per cycle and routes the word by its destination ID
// (top 8 bits). The word goes to one device, to every device except the
// source (ID 8'hFF), or nowhere (ID outside 0..DEVICES-1).
//
// Parameters:
//   WIDTH   packet width in bits (>= 9), [WIDTH-1:WIDTH-8] = destination ID
//   DEPTH   entries per device FIFO (power of 2, >= 2)
//   DEVICES number of attached devices (2..16)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   push       per-device write strobe
//   d_in       per-device packet, slice i = [i*WIDTH +: WIDTH]
//   full       per-device FIFO full flag (registered)
//   d_out      per-device delivered packet, holds value while not valid
//   d_out_vld  per-device delivery strobe, one cycle per packet
//   drop_cnt   (only with TEST_DROP_CNT_EN) saturating count of rejected
//              pushes plus dropped packets
//
// Optional feature macro: TEST_DROP_CNT_EN

module test #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int DEVICES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DEVICES-1:0]       push,
  input  logic [DEVICES*WIDTH-1:0] d_in,
  output logic [DEVICES-1:0]       full,
  output logic [DEVICES*WIDTH-1:0] d_out,
  output logic [DEVICES-1:0]       d_out_vld
`ifdef TEST_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (DEVICES > 1) ? $clog2(DEVICES) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [IW:0]   DEV_C   = (IW+1)'(DEVICES);
  localparam logic [IW-1:0] LAST_C  = IW'(DEVICES - 1);
  localparam logic [7:0]    BCAST   = 8'hFF;

  logic [WIDTH-1:0]   mem   [DEVICES][DEPTH];
  logic [AW-1:0]      wptr  [DEVICES];
  logic [AW-1:0]      rptr  [DEVICES];
  logic [AW:0]        count [DEVICES];
  logic [AW:0]        count_nxt [DEVICES];

  logic [DEVICES-1:0] wr_en;
  logic [DEVICES-1:0] rd_en;
  logic [DEVICES-1:0] nonempty;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [IW:0]        cand;

  logic [WIDTH-1:0]   head;
  logic [7:0]         dest;
  logic               is_bcast;

  // A push is accepted only while the FIFO is not full; the full flag is the
  // registered image of count==DEPTH, so it is exact for the current cycle.
  // Pops come only from the arbiter grant.
  always_comb begin
    wr_en    = '0;
    rd_en    = '0;
    nonempty = '0;
    for (int i = 0; i < DEVICES; i++) begin
      nonempty[i] = (count[i] != '0);
      wr_en[i]    = push[i] & ~full[i];
      rd_en[i]    = gnt_vld && (gnt_idx == IW'(i));
    end
  end

  // Round-robin search: walk the devices starting at rr_ptr (one past the
  // last winner) and take the first non-empty FIFO. The candidate index is
  // kept one bit wider so the wrap-around subtraction works for any DEVICES.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < DEVICES; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= DEV_C) begin
        cand = cand - DEV_C;
      end
      if (!gnt_vld && nonempty[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  // Head word of the granted FIFO and its routing class.
  always_comb begin
    head     = mem[gnt_idx][rptr[gnt_idx]];
    dest     = head[WIDTH-1 -: 8];
    is_bcast = gnt_vld && (dest == BCAST);
  end

  // Next occupancy per FIFO; push and pop in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < DEVICES; i++) begin
      count_nxt[i] = count[i] + (AW+1)'(wr_en[i]) - (AW+1)'(rd_en[i]);
    end
  end

  // FIFO storage carries no reset: stale words are unreachable once the
  // pointers and counts are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEVICES; i++) begin
      if (wr_en[i]) begin
        mem[i][wptr[i]] <= d_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // FIFO pointers, counts and the registered full flag. Pointers are AW bits
  // wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEVICES; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
      full <= '0;
    end else begin
      for (int i = 0; i < DEVICES; i++) begin
        if (wr_en[i]) begin
          wptr[i] <= wptr[i] + 1'b1;
        end
        if (rd_en[i]) begin
          rptr[i] <= rptr[i] + 1'b1;
        end
        count[i] <= count_nxt[i];
        full[i]  <= (count_nxt[i] == DEPTH_C);
      end
    end
  end

  // Arbiter pointer: the next search starts just after the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == LAST_C) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Delivery stage. A broadcast lands on every slice except the source's;
  // a unicast lands on the slice matching its ID. An out-of-range ID matches
  // no slice, so the word is popped and silently dropped. Slices that are
  // not written keep their previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out     <= '0;
      d_out_vld <= '0;
    end else begin
      d_out_vld <= '0;
      if (gnt_vld) begin
        for (int j = 0; j < DEVICES; j++) begin
          if ((is_bcast && (gnt_idx != IW'(j))) ||
              (!is_bcast && (dest == 8'(j)))) begin
            d_out[j*WIDTH +: WIDTH] <= head;
            d_out_vld[j]            <= 1'b1;
          end
        end
      end
    end
  end

`ifdef TEST_DROP_CNT_EN
  logic [4:0]  rej_cnt;
  logic        is_drop;
  logic [16:0] drop_sum;

  // Rejected pushes and a dropped packet may land in the same cycle; all of
  // them are added together and the sum saturates at 16'hFFFF.
  always_comb begin
    rej_cnt = '0;
    for (int i = 0; i < DEVICES; i++) begin
      rej_cnt = rej_cnt + 5'(push[i] & full[i]);
    end
    is_drop  = gnt_vld && !is_bcast && (dest >= 8'(DEVICES));
    drop_sum = 17'(drop_cnt) + 17'(rej_cnt) + 17'(is_drop);
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_test.sv
// tb_test -- directed bench for the packet switch (WIDTH=16, DEPTH=8,
// DEVICES=4). A table of per-cycle vectors covers unicast, broadcast,
// loopback, round-robin order and dropping; hand-written sequences cover
// reset in mid-flight and FIFO full behaviour.

module tb_test;

  logic        clk;
  logic        rst_n;
  logic [3:0]  push;
  logic [63:0] d_in;
  logic [3:0]  full;
  logic [63:0] d_out;
  logic [3:0]  d_out_vld;
`ifdef TEST_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks;
  int failures;

  logic        collect;
  logic [15:0] got3[$];

  typedef struct {
    logic [3:0]  push;
    logic [63:0] din;
    logic [3:0]  exp_full;
    logic [3:0]  exp_vld;
    logic [63:0] exp_dout;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[16];

  test #(.WIDTH(16), .DEPTH(8), .DEVICES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .d_in     (d_in),
    .full     (full),
    .d_out    (d_out),
    .d_out_vld(d_out_vld)
`ifdef TEST_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records every word delivered on slice 3 while collection is enabled,
  // sampled on the falling edge.
  always @(negedge clk) begin
    if (collect && d_out_vld[3]) begin
      got3.push_back(d_out[63:48]);
    end
  end

  // Drive one cycle of inputs, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic [3:0] p, input logic [63:0] din);
    push = p;
    d_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    collect  = 1'b0;
    rst_n    = 1'b0;
    push     = '0;
    d_in     = '0;

    // Vector table: inputs applied before an edge, outputs expected after it.
    vecs[0]  = '{push:4'b0001, din:64'h0000_0000_0000_02A5, exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0000_0000_0000_0000, exp_drop:16'd0};
    vecs[1]  = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0100, exp_dout:64'h0000_02A5_0000_0000, exp_drop:16'd0};
    vecs[2]  = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0000_02A5_0000_0000, exp_drop:16'd0};
    vecs[3]  = '{push:4'b0010, din:64'h0000_0000_FF3C_0000, exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0000_02A5_0000_0000, exp_drop:16'd0};
    vecs[4]  = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b1101, exp_dout:64'hFF3C_FF3C_0000_FF3C, exp_drop:16'd0};
    vecs[5]  = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'hFF3C_FF3C_0000_FF3C, exp_drop:16'd0};
    vecs[6]  = '{push:4'b1000, din:64'h0399_0000_0000_0000, exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'hFF3C_FF3C_0000_FF3C, exp_drop:16'd0};
    vecs[7]  = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b1000, exp_dout:64'h0399_FF3C_0000_FF3C, exp_drop:16'd0};
    vecs[8]  = '{push:4'b1111, din:64'h0043_0032_0021_0010, exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0399_FF3C_0000_FF3C, exp_drop:16'd0};
    vecs[9]  = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0001, exp_dout:64'h0399_FF3C_0000_0010, exp_drop:16'd0};
    vecs[10] = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0001, exp_dout:64'h0399_FF3C_0000_0021, exp_drop:16'd0};
    vecs[11] = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0001, exp_dout:64'h0399_FF3C_0000_0032, exp_drop:16'd0};
    vecs[12] = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0001, exp_dout:64'h0399_FF3C_0000_0043, exp_drop:16'd0};
    vecs[13] = '{push:4'b0001, din:64'h0000_0000_0000_0711, exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0399_FF3C_0000_0043, exp_drop:16'd0};
    vecs[14] = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0399_FF3C_0000_0043, exp_drop:16'd1};
    vecs[15] = '{push:4'b0000, din:64'h0,                   exp_full:4'b0000, exp_vld:4'b0000, exp_dout:64'h0399_FF3C_0000_0043, exp_drop:16'd1};

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_full", 64'(full), 64'h0);
    checkOutput("reset_vld",  64'(d_out_vld), 64'h0);
    checkOutput("reset_dout", d_out, 64'h0);
`ifdef TEST_DROP_CNT_EN
    checkOutput("reset_drop", 64'(drop_cnt), 64'h0);
`endif
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int r = 0; r < 16; r++) begin
      applyStimulus(vecs[r].push, vecs[r].din);
      checkOutput($sformatf("row%0d_full", r), 64'(full),      64'(vecs[r].exp_full));
      checkOutput($sformatf("row%0d_vld", r),  64'(d_out_vld), 64'(vecs[r].exp_vld));
      checkOutput($sformatf("row%0d_dout", r), d_out,          vecs[r].exp_dout);
`ifdef TEST_DROP_CNT_EN
      checkOutput($sformatf("row%0d_drop", r), 64'(drop_cnt),  64'(vecs[r].exp_drop));
`endif
    end

    // Reset mid-operation: three words queued (dest 3), one already in
    // flight when reset hits. The arbiter resumes at device 1 here.
    applyStimulus(4'b0111, 64'h0000_0303_0302_0301);
    applyStimulus(4'b0000, 64'h0);
    checkOutput("inflight_vld",  64'(d_out_vld),   64'h8);
    checkOutput("inflight_dout", 64'(d_out[63:48]), 64'h0302);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_full", 64'(full), 64'h0);
    checkOutput("midrst_vld",  64'(d_out_vld), 64'h0);
    checkOutput("midrst_dout", d_out, 64'h0);
`ifdef TEST_DROP_CNT_EN
    checkOutput("midrst_drop", 64'(drop_cnt), 64'h0);
`endif
    push = 4'b1111;
    d_in = 64'h0055_0055_0055_0055;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstpush_full", 64'(full), 64'h0);
    checkOutput("rstpush_vld",  64'(d_out_vld), 64'h0);
    push  = 4'b0000;
    d_in  = 64'h0;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0000, 64'h0);
      checkOutput($sformatf("postrst_vld%0d", c), 64'(d_out_vld), 64'h0);
    end

    // Fill: every device pushes 11 words back to back while the arbiter
    // rotates 0,1,2,3. Device 3 is popped at edges 4, 8 and 12, so it hits
    // 8 entries at edge 9, its 11th word is rejected at edge 10, and it
    // leaves full at edge 12. Devices 1 and 2 also reject one word each at
    // edge 10.
    got3.delete();
    collect = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      logic [63:0] dv;
      dv = {16'h0300 | 16'(n), 16'h0200 | 16'(n), 16'h0100 | 16'(n), 16'(n)};
      applyStimulus(4'b1111, dv);
      if (n == 8) checkOutput("full3_e8",  64'(full[3]), 64'h0);
      if (n == 9) checkOutput("full3_e9",  64'(full[3]), 64'h1);
      if (n == 10) checkOutput("full3_e10", 64'(full[3]), 64'h1);
`ifdef TEST_DROP_CNT_EN
      if (n == 9) checkOutput("drop_e9",  64'(drop_cnt), 64'h0);
      if (n == 10) checkOutput("drop_e10", 64'(drop_cnt), 64'h3);
`endif
    end
    applyStimulus(4'b0000, 64'h0);
    checkOutput("full3_e11", 64'(full[3]), 64'h1);
    applyStimulus(4'b0000, 64'h0);
    checkOutput("full3_e12", 64'(full[3]), 64'h0);
    repeat (60) applyStimulus(4'b0000, 64'h0);
    collect = 1'b0;
    checkOutput("drain_full", 64'(full), 64'h0);
    checkOutput("dev3_count", 64'(got3.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < got3.size()) begin
        checkOutput($sformatf("dev3_word%0d", k), 64'(got3[k]), 64'(16'h0300 | 16'(k)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
